// File: rtl/rst_sink.sv
// rst_sink: per-domain reset conditioner.
// The incoming active-low reset is asserted asynchronously and released synchronously.
// After release, rst_out stays low for HOLD_CYCLES more cycles.
// A one-cycle software request in RUN produces a timed reset pulse.
// Optional feature: define RST_SINK_EVENT_CNT_EN to build the rst_events counter.
// Without that macro, rst_events is tied to zero.
module rst_sink #(
   parameter int SYNC_STAGES = 2,
   parameter int HOLD_CYCLES = 16,
   parameter int SW_LEN      = 8,
   parameter int CNT_W       = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sw_rst_req,
   output logic             rst_out,
   output logic             rst_busy,
   output logic             rst_done,
   output logic [CNT_W-1:0] rst_events
);

   typedef enum logic [2:0] {
      S_RESET,
      S_SYNC,
      S_HOLD,
      S_SWRST,
      S_RUN
   } state_t;

   localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES - 1);
   localparam logic [7:0] SW_LOAD   = 8'(SW_LEN - 1);

   state_t                 state, state_nx;
   logic [7:0]             cnt, cnt_nx;
   logic                   out_nx;
   logic                   done_nx;
   logic [SYNC_STAGES-1:0] sync_q;

   // Release synchronizer: fills with ones once rst is high, stays full afterwards.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) sync_q <= '0;
      else      sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
   end

   // State, counter and the single output flops for rst_out / rst_done.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= S_RESET;
         cnt      <= '0;
         rst_out  <= 1'b0;
         rst_done <= 1'b0;
      end else begin
         state    <= state_nx;
         cnt      <= cnt_nx;
         rst_out  <= out_nx;
         rst_done <= done_nx;
      end
   end

   // Next-state logic.
   // SYNC ends on the edge where the last stage fills, i.e. when the stage before it is already 1.
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      out_nx   = rst_out;
      done_nx  = 1'b0;
      case (state)
         S_RESET: state_nx = S_SYNC;
         S_SYNC: begin
            if (sync_q[SYNC_STAGES-2]) begin
               state_nx = S_HOLD;
               cnt_nx   = HOLD_LOAD;
            end
         end
         S_HOLD: begin
            if (cnt == '0) begin
               state_nx = S_RUN;
               out_nx   = 1'b1;
               done_nx  = 1'b1;
            end else begin
               cnt_nx = cnt - 8'd1;
            end
         end
         S_SWRST: begin
            if (cnt == '0) begin
               state_nx = S_HOLD;
               cnt_nx   = HOLD_LOAD;
            end else begin
               cnt_nx = cnt - 8'd1;
            end
         end
         S_RUN: begin
            if (sw_rst_req) begin
               state_nx = S_SWRST;
               cnt_nx   = SW_LOAD;
               out_nx   = 1'b0;
            end
         end
         default: state_nx = S_RESET;
      endcase
   end

   assign rst_busy = (state != S_RUN);

`ifdef RST_SINK_EVENT_CNT_EN
   logic             ev_inc;
   logic [CNT_W-1:0] ev_q;

   // A software sequence completes on the SWRST to HOLD transition.
   always_comb begin
      ev_inc = (state == S_SWRST) && (cnt == '0);
   end

   // Saturating count of completed software resets.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                       ev_q <= '0;
      else if (ev_inc && ev_q != '1)  ev_q <= ev_q + CNT_W'(1);
   end

   assign rst_events = ev_q;
`else
   assign rst_events = '0;
`endif

endmodule

// File: tb/tb_rst_sink.sv
// tb_rst_sink: scoreboard bench for rst_sink.
// A reference model predicts each rst_out rise from the release and request rules.
// A monitor checks each rst_done pulse and the per-cycle reset level.
module tb_rst_sink;

   localparam int S      = 2;
   localparam int H      = 16;
   localparam int SW     = 8;
   localparam int CW     = 2;
   localparam int EV_MAX = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          sw_rst_req = 1'b0;
   logic          rst_out, rst_busy, rst_done;
   logic [CW-1:0] rst_events;

   rst_sink #(
      .SYNC_STAGES(S),
      .HOLD_CYCLES(H),
      .SW_LEN     (SW),
      .CNT_W      (CW)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .sw_rst_req(sw_rst_req),
      .rst_out   (rst_out),
      .rst_busy  (rst_busy),
      .rst_done  (rst_done),
      .rst_events(rst_events)
   );

   always #5 clk = ~clk;

   typedef struct {
      int rise;
      int ev;
   } exp_t;

   exp_t q[$];
   int   cyc       = 0;
   int   since_rel = 0;
   int   up_at     = 0;
   int   ev        = 0;
   int   checks    = 0;
   int   errors    = 0;
   bit   model_up  = 1'b0;

   function automatic int ev_exp(input int e);
`ifdef RST_SINK_EVENT_CNT_EN
      return e;
`else
      return 0;
`endif
   endfunction

   // Reference model.
   // Release edge 1 gives a rise at edge S+H.
   // A request accepted at edge N (only while up) gives a rise at N+SW+H.
   always @(posedge clk or negedge rst) begin
      exp_t e;
      if (!rst) begin
         since_rel = 0;
         up_at     = 0;
         model_up  = 1'b0;
         ev        = 0;
         q.delete();
      end else begin
         cyc++;
         since_rel++;
         if (model_up && sw_rst_req) begin
            model_up = 1'b0;
            if (ev < EV_MAX) ev++;
            up_at  = cyc + SW + H;
            e.rise = up_at;
            e.ev   = ev_exp(ev);
            q.push_back(e);
         end
         if (since_rel == 1) begin
            up_at  = cyc + S + H - 1;
            e.rise = up_at;
            e.ev   = 0;
            q.push_back(e);
         end
         if (cyc == up_at) model_up = 1'b1;
      end
   end

   // Monitor: compares every rst_done pulse with the scoreboard and checks the reset level each cycle.
   always @(negedge clk) begin
      exp_t e;
      if (rst_done) begin
         checks++;
         if (q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_done cyc=%0d got rst_done=1 required no pulse", cyc);
         end else begin
            e = q.pop_front();
            if (cyc != e.rise || int'(rst_events) != e.ev) begin
               errors++;
               $display("FAIL done cyc=%0d events=%0d required cyc=%0d events=%0d",
                        cyc, rst_events, e.rise, e.ev);
            end
         end
      end else if (q.size() != 0 && cyc >= q[0].rise) begin
         checks++;
         errors++;
         $display("FAIL missing_done cyc=%0d got rst_done=0 required pulse at cyc=%0d", cyc, q[0].rise);
         void'(q.pop_front());
      end
      checks++;
      if (rst_out !== model_up || rst_busy !== !model_up) begin
         errors++;
         $display("FAIL level cyc=%0d rst_out=%b rst_busy=%b required rst_out=%b rst_busy=%b",
                  cyc, rst_out, rst_busy, model_up, !model_up);
      end
   end

   // Assert rst mid-cycle and check the outputs clear immediately without any clock edge.
   task automatic async_reset(input string tag);
      @(negedge clk);
      #2 rst = 1'b0;
      #1;
      checks++;
      if (rst_out !== 1'b0 || rst_busy !== 1'b1 || rst_done !== 1'b0 || rst_events !== '0) begin
         errors++;
         $display("FAIL %s out=%b busy=%b done=%b events=%0d required out=0 busy=1 done=0 events=0",
                  tag, rst_out, rst_busy, rst_done, rst_events);
      end
   endtask

   task automatic sw_pulse();
      @(negedge clk);
      sw_rst_req = 1'b1;
      @(negedge clk);
      sw_rst_req = 1'b0;
      repeat (30) @(negedge clk);
   endtask

   initial begin
      int r;
      int n;

      // Power-on: rst low for 5 cycles, then released.
      repeat (5) @(negedge clk);
      checks++;
      if (rst_out !== 1'b0 || rst_busy !== 1'b1 || rst_done !== 1'b0 || rst_events !== '0) begin
         errors++;
         $display("FAIL por out=%b busy=%b done=%b events=%0d required out=0 busy=1 done=0 events=0",
                  rst_out, rst_busy, rst_done, rst_events);
      end
      rst = 1'b1;
      repeat (30) @(negedge clk);

      // Reset pulsed in the middle of HOLD (edge 10), then a full release.
      async_reset("pre_mid_hold");
      repeat (3) @(negedge clk);
      rst = 1'b1;
      repeat (9) @(negedge clk);
      async_reset("mid_hold");
      repeat (3) @(negedge clk);
      rst = 1'b1;
      repeat (30) @(negedge clk);

      // Software reset from RUN.
      sw_pulse();

      // Request held high through RESET/SYNC/HOLD is ignored.
      async_reset("pre_ignored");
      repeat (2) @(negedge clk);
      rst = 1'b1;
      sw_rst_req = 1'b1;
      repeat (17) @(negedge clk);
      sw_rst_req = 1'b0;
      repeat (30) @(negedge clk);

      // Short glitches: rst high for 1 and for 2 cycles.
      async_reset("pre_glitch");
      @(negedge clk);
      rst = 1'b1;
      async_reset("glitch1");
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      async_reset("glitch2");
      repeat (20) @(negedge clk);
      rst = 1'b1;
      repeat (30) @(negedge clk);

      // Five software resets: the event count saturates at 3.
      for (int i = 0; i < 5; i++) sw_pulse();

      // Randomized requests and reset pulses.
      for (int i = 0; i < 1500; i++) begin
         @(negedge clk);
         r = $urandom_range(0, 99);
         sw_rst_req = (r < 5);
         if (r == 99) begin
            sw_rst_req = 1'b0;
            n = $urandom_range(1, 6);
            async_reset("rand_reset");
            repeat (n) @(negedge clk);
            rst = 1'b1;
         end
      end
      sw_rst_req = 1'b0;
      repeat (60) @(negedge clk);

      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain pending=%0d required 0", q.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
